cpu_run_monitor: RTL and testbench

Synthesizable run controller and monitor for the `cpu` core. It sequences the CPU reset for a parametrised number of cycles after the system reset releases, then counts run cycles. It ends the run on a pass code, a fail code, or a programmable timeout, and reports the outcome on registered status outputs. It sits between the board/bench reset and `cpu`: it drives `cpu.rstn` and watches `cpu.io_out`, so the same run/timeout policy applies on FPGA and in simulation.

---
 rtl/sim_ctrl_pkg.sv | 15 +
 rtl/sat_counter.sv | 37 +++
 rtl/cpu_run_monitor.sv | 146 ++++++++++++++
 tb/tb_cpu_run_monitor.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_ctrl_pkg.sv
// Shared simulation-control definitions: run-state encoding and the default
// pass/fail/timeout values used by the run monitor and the CPU benches.
package sim_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } run_state_t;

  localparam logic [31:0] DEFAULT_PASS_CODE = 32'h0000_600D;
  localparam logic [31:0] DEFAULT_FAIL_CODE = 32'h0000_0BAD;
  localparam int unsigned DEFAULT_TIMEOUT   = 10000;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != MAX_VAL)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller for the cpu core: holds the CPU in reset for RST_HOLD cycles,
// then counts run cycles until a pass code, fail code or cycle limit is seen.
module cpu_run_monitor
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned     IO_W         = 32,
  parameter int unsigned     CNT_W        = 32,
  parameter int unsigned     RST_HOLD     = 2,
  parameter int unsigned     TIMEOUT      = DEFAULT_TIMEOUT,
  parameter logic [IO_W-1:0] PASS_CODE    = IO_W'(DEFAULT_PASS_CODE),
  parameter logic [IO_W-1:0] FAIL_CODE    = IO_W'(DEFAULT_FAIL_CODE),
  parameter bit              HALT_ON_DONE = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             restart,
  input  logic [IO_W-1:0]  io_out,
  output logic             cpu_rstn,
  output logic [CNT_W-1:0] cycle_count,
  output logic [IO_W-1:0]  result,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout
);

  localparam int unsigned      HOLD_W     = $clog2(RST_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [63:0]      LIMIT      = 64'(TIMEOUT);

  run_state_t        state_q, state_d;
  logic              cpu_rstn_q, cpu_rstn_d;
  logic [IO_W-1:0]   result_q, result_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              timeout_q, timeout_d;

  logic [HOLD_W-1:0] hold_cnt;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [CNT_W-1:0]  cycle_inc;
  logic              hold_last;
  logic              pass_hit;
  logic              fail_hit;
  logic              timeout_hit;

  assign hold_last = (state_q == HOLD) && (hold_cnt == HOLD_LAST);

  sat_counter #(.WIDTH(HOLD_W)) u_hold_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (restart || hold_last),
    .en    (state_q == HOLD),
    .count (hold_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (restart),
    .en    (state_q == RUN),
    .count (cycle_cnt)
  );

  // The limit is compared against the count this edge will produce, so the
  // exit edge itself is included in the reported count.
  assign cycle_inc   = (cycle_cnt == CNT_MAX) ? cycle_cnt : cycle_cnt + CNT_W'(1);
  assign pass_hit    = (io_out == PASS_CODE);
  assign fail_hit    = (io_out == FAIL_CODE);
  assign timeout_hit = (TIMEOUT != 0) && (64'(cycle_inc) == LIMIT);

  always_comb begin
    state_d    = state_q;
    cpu_rstn_d = cpu_rstn_q;
    result_d   = result_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    timeout_d  = timeout_q;
    if (restart) begin
      state_d    = HOLD;
      cpu_rstn_d = 1'b0;
      result_d   = '0;
      done_d     = 1'b0;
      pass_d     = 1'b0;
      fail_d     = 1'b0;
      timeout_d  = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (hold_last) begin
            state_d    = RUN;
            cpu_rstn_d = 1'b1;
          end
        end
        RUN: begin
          if (pass_hit || fail_hit || timeout_hit) begin
            state_d    = DONE;
            cpu_rstn_d = !HALT_ON_DONE;
            result_d   = io_out;
            done_d     = 1'b1;
            pass_d     = pass_hit;
            fail_d     = !pass_hit && fail_hit;
            timeout_d  = !pass_hit && !fail_hit;
          end
        end
        DONE: begin
        end
        default: begin
          state_d    = HOLD;
          cpu_rstn_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= HOLD;
      cpu_rstn_q <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpu_rstn_q <= cpu_rstn_d;
      result_q   <= result_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      timeout_q  <= timeout_d;
    end
  end

  assign cpu_rstn    = cpu_rstn_q;
  assign cycle_count = cycle_cnt;
  assign result      = result_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: a main instance with RST_HOLD=3/TIMEOUT=100 and a
// narrow-counter instance with the timeout disabled.
module tb_cpu_run_monitor;
  import sim_ctrl_pkg::*;

  localparam logic [31:0] PASS_VAL = 32'h0000_600D;
  localparam logic [31:0] BAD_VAL  = 32'h0000_0BAD;

  typedef struct packed {
    logic [31:0] res;
    logic        ps;
    logic        fl;
    logic        tmo;
    logic        dn;
    logic        crst;
    logic [31:0] cnt;
  } outcome_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        restart = 1'b0;
  logic [31:0] io_out = '0;
  logic        cpu_rstn;
  logic [31:0] cycle_count;
  logic [31:0] result;
  logic        done, pass, fail, timeout;

  logic        rstn_b = 1'b0;
  logic        restart_b = 1'b0;
  logic [31:0] io_b = '0;
  logic        cpu_rstn_b;
  logic [3:0]  cnt_b;
  logic [31:0] result_b;
  logic        done_b, pass_b, fail_b, timeout_b;

  outcome_t sb[$];
  int       cnt_sb[$];
  int       vectors = 0;
  int       errors  = 0;

  always #5 clk = ~clk;

  cpu_run_monitor #(
    .IO_W(32), .CNT_W(32), .RST_HOLD(3), .TIMEOUT(100),
    .PASS_CODE(PASS_VAL), .FAIL_CODE(BAD_VAL), .HALT_ON_DONE(1'b1)
  ) dut (
    .clk(clk), .rstn(rstn), .restart(restart), .io_out(io_out),
    .cpu_rstn(cpu_rstn), .cycle_count(cycle_count), .result(result),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout)
  );

  cpu_run_monitor #(
    .IO_W(32), .CNT_W(4), .RST_HOLD(1), .TIMEOUT(0),
    .PASS_CODE(PASS_VAL), .FAIL_CODE(BAD_VAL), .HALT_ON_DONE(1'b1)
  ) dut_sat (
    .clk(clk), .rstn(rstn_b), .restart(restart_b), .io_out(io_b),
    .cpu_rstn(cpu_rstn_b), .cycle_count(cnt_b), .result(result_b),
    .done(done_b), .pass(pass_b), .fail(fail_b), .timeout(timeout_b)
  );

  function automatic outcome_t observe();
    outcome_t o;
    o.res  = result;
    o.ps   = pass;
    o.fl   = fail;
    o.tmo  = timeout;
    o.dn   = done;
    o.crst = cpu_rstn;
    o.cnt  = cycle_count;
    return o;
  endfunction

  function automatic string fmt(outcome_t o);
    return $sformatf("res=%h p=%b f=%b t=%b d=%b crst=%b cnt=%0d",
                     o.res, o.ps, o.fl, o.tmo, o.dn, o.crst, o.cnt);
  endfunction

  function automatic outcome_t mk(logic [31:0] res, logic ps, logic fl, logic tmo, int cnt);
    outcome_t o;
    o.res  = res;
    o.ps   = ps;
    o.fl   = fl;
    o.tmo  = tmo;
    o.dn   = 1'b1;
    o.crst = 1'b0;
    o.cnt  = cnt;
    return o;
  endfunction

  task automatic do_reset();
    rstn    = 1'b0;
    restart = 1'b0;
    io_out  = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Leaves the main instance in RUN with cycle_count still 0.
  task automatic enter_run();
    do_reset();
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    outcome_t got;
    rstn = 1'b0;
    #3;
    got = observe();
    vectors++;
    if (got !== outcome_t'('0)) begin
      errors++;
      $display("[TB] FAIL reset_values: got %s, want all zero", fmt(got));
    end
    vectors++;
    if ({cpu_rstn_b, cnt_b, done_b, pass_b, fail_b, timeout_b} !== 9'd0 || result_b !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_values_sat: crst=%b cnt=%0d d=%b, want zero", cpu_rstn_b, cnt_b, done_b);
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      vectors++;
      if (cpu_rstn !== (e == 3) || cycle_count !== 32'd0) begin
        errors++;
        $display("[TB] FAIL hold_edge%0d: crst=%b cnt=%0d, want crst=%b cnt=0",
                 e, cpu_rstn, cycle_count, (e == 3));
      end
    end
    @(negedge clk);
    vectors++;
    if (cycle_count !== 32'd1) begin
      errors++;
      $display("[TB] FAIL first_run_edge: cnt=%0d, want 1", cycle_count);
    end
  endtask

  task automatic test_pass();
    outcome_t got, exp;
    bit seen;
    enter_run();
    sb.push_back(mk(PASS_VAL, 1'b1, 1'b0, 1'b0, 25));
    repeat (24) @(negedge clk);
    io_out = PASS_VAL;
    wait_done(10, seen);
    io_out = '0;
    exp = sb.pop_front();
    got = observe();
    vectors++;
    if (!seen || got !== exp) begin
      errors++;
      $display("[TB] FAIL pass_after_25: got %s, want %s", fmt(got), fmt(exp));
    end
    // DONE must ignore io_out, including a fail code.
    io_out = BAD_VAL;
    repeat (5) @(negedge clk);
    io_out = '0;
    got = observe();
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL done_holds: got %s, want %s", fmt(got), fmt(exp));
    end
  endtask

  task automatic test_timeout();
    outcome_t got, exp;
    bit seen;
    enter_run();
    sb.push_back(mk(32'd0, 1'b0, 1'b0, 1'b1, 100));
    wait_done(150, seen);
    exp = sb.pop_front();
    got = observe();
    vectors++;
    if (!seen || got !== exp) begin
      errors++;
      $display("[TB] FAIL timeout_100: got %s, want %s", fmt(got), fmt(exp));
    end
  endtask

  task automatic test_fail();
    outcome_t got, exp;
    bit seen;
    enter_run();
    sb.push_back(mk(BAD_VAL, 1'b0, 1'b1, 1'b0, 11));
    repeat (10) @(negedge clk);
    io_out = BAD_VAL;
    wait_done(10, seen);
    io_out = '0;
    exp = sb.pop_front();
    got = observe();
    vectors++;
    if (!seen || got !== exp) begin
      errors++;
      $display("[TB] FAIL fail_code: got %s, want %s", fmt(got), fmt(exp));
    end
  endtask

  task automatic test_pass_at_timeout();
    outcome_t got, exp;
    bit seen;
    enter_run();
    sb.push_back(mk(PASS_VAL, 1'b1, 1'b0, 1'b0, 100));
    repeat (99) @(negedge clk);
    io_out = PASS_VAL;
    wait_done(10, seen);
    io_out = '0;
    exp = sb.pop_front();
    got = observe();
    vectors++;
    if (!seen || got !== exp) begin
      errors++;
      $display("[TB] FAIL pass_beats_timeout: got %s, want %s", fmt(got), fmt(exp));
    end
  endtask

  task automatic test_restart();
    outcome_t got;
    @(negedge clk);
    restart = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      got = observe();
      vectors++;
      if (got !== outcome_t'('0)) begin
        errors++;
        $display("[TB] FAIL restart_held%0d: got %s, want all zero", i, fmt(got));
      end
    end
    restart = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      vectors++;
      if (cpu_rstn !== (e == 3)) begin
        errors++;
        $display("[TB] FAIL restart_hold_edge%0d: crst=%b, want %b", e, cpu_rstn, (e == 3));
      end
    end
  endtask

  task automatic test_async_reset();
    outcome_t got;
    enter_run();
    repeat (10) @(negedge clk);
    vectors++;
    if (cycle_count !== 32'd10 || cpu_rstn !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_run: cnt=%0d crst=%b, want cnt=10 crst=1", cycle_count, cpu_rstn);
    end
    #2 rstn = 1'b0;
    #1;
    got = observe();
    vectors++;
    if (got !== outcome_t'('0)) begin
      errors++;
      $display("[TB] FAIL async_reset: got %s, want all zero", fmt(got));
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      vectors++;
      if (cpu_rstn !== (e == 3)) begin
        errors++;
        $display("[TB] FAIL rehold_edge%0d: crst=%b, want %b", e, cpu_rstn, (e == 3));
      end
    end
  endtask

  task automatic test_saturate();
    int exp_cnt;
    io_b = '0;
    @(negedge clk);
    rstn_b = 1'b1;
    @(negedge clk);
    vectors++;
    if (cpu_rstn_b !== 1'b1 || cnt_b !== 4'd0) begin
      errors++;
      $display("[TB] FAIL sat_hold1: crst=%b cnt=%0d, want crst=1 cnt=0", cpu_rstn_b, cnt_b);
    end
    for (int i = 1; i <= 20; i++) begin
      cnt_sb.push_back((i > 15) ? 15 : i);
      @(negedge clk);
      exp_cnt = cnt_sb.pop_front();
      vectors++;
      if (cnt_b !== 4'(exp_cnt) || done_b !== 1'b0) begin
        errors++;
        $display("[TB] FAIL sat_edge%0d: cnt=%0d done=%b, want cnt=%0d done=0",
                 i, cnt_b, done_b, exp_cnt);
      end
    end
  endtask

  initial begin
    $display("[TB] starting cpu_run_monitor bench");
    test_reset();
    test_pass();
    test_timeout();
    test_fail();
    test_pass_at_timeout();
    test_restart();
    test_async_reset();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
